// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and writeback after the ALU.
// Optional MEM watchdog and sticky mem_err: define MEM_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [31:0]       in_result,
  input  logic [31:0]       in_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic              retire,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    WB
  } state_t;

  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  function automatic logic writes_rf(
    input logic [3:0] op
  );
    return !(op == OP_CMP ||
             op == OP_STR ||
             op == OP_NOP);
  endfunction

  state_t state, state_n;

  logic [3:0]  op_q;
  logic [3:0]  rd_q;
  logic [31:0] result_q;

  logic              ready_n;
  logic              req_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;
  logic              wb_en_n;
  logic [3:0]        wb_addr_n;
  logic [31:0]       wb_data_n;
  logic              retire_n;
  logic              xfer;
  logic              is_mem_op;

  assign xfer      = in_valid && in_ready;
  assign is_mem_op = (in_opcode == OP_LDR) ||
                     (in_opcode == OP_STR);

`ifdef MEM_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CLOG > 8) ? CLOG : 8;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_q, err_n;

  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign mem_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n   = state;
    req_n     = mem_req;
    we_n      = mem_we;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    wb_en_n   = 1'b0;
    retire_n  = 1'b0;
    wb_addr_n = wb_addr;
    wb_data_n = wb_data;
`ifdef MEM_TIMEOUT_EN
    cnt_n = cnt;
    err_n = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (is_mem_op) begin
            state_n = MEM;
            req_n   = 1'b1;
            we_n    = (in_opcode == OP_STR);
            addr_n  = in_result[ADDR_W-1:0];
            if (in_opcode == OP_STR)
              wdata_n = in_store_data;
`ifdef MEM_TIMEOUT_EN
            cnt_n = '0;
`endif
          end else begin
            state_n   = WB;
            wb_en_n   = writes_rf(in_opcode);
            retire_n  = 1'b1;
            wb_addr_n = in_rd;
            wb_data_n = in_result;
          end
        end
      end
      MEM: begin
        if (mem_req && mem_ack) begin
          state_n   = WB;
          req_n     = 1'b0;
          we_n      = 1'b0;
          wb_en_n   = writes_rf(op_q);
          retire_n  = 1'b1;
          wb_addr_n = rd_q;
          wb_data_n = (op_q == OP_LDR) ?
                      mem_rdata : result_q;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt == TO_LAST) begin
            state_n  = WB;
            req_n    = 1'b0;
            we_n     = 1'b0;
            retire_n = 1'b1;
            err_n    = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
`endif
        end
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  // Registered outputs; in_ready mirrors the next IDLE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      retire    <= 1'b0;
    end else begin
      in_ready  <= ready_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      wb_en     <= wb_en_n;
      wb_addr   <= wb_addr_n;
      wb_data   <= wb_data_n;
      retire    <= retire_n;
    end
  end

  // Instruction fields held for the memory phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NOP;
      rd_q     <= '0;
      result_q <= '0;
    end else if (xfer) begin
      op_q     <= in_opcode;
      rd_q     <= in_rd;
      result_q <= in_result;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed stimulus, queue scoreboard
// and a negedge monitor for writeback and memory traffic.
module tb_mem_wb_stage;

  localparam int ADDR_W = 16;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        retire;
  logic        mem_err;

  mem_wb_stage #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_rd(in_rd),
    .in_result(in_result),
    .in_store_data(in_store_data),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .retire(retire),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic        en;
    logic [3:0]  addr;
    logic [31:0] data;
    int          lat;
    int          t0;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } mem_exp_t;

  wb_exp_t  wbq[$];
  mem_exp_t memq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT retires
  // or finishes a memory request.
  wb_exp_t     e;
  mem_exp_t    m;
  int          req_cnt = 0;
  logic        m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;

  always @(negedge clk) begin
    if (retire) begin
      if (wbq.size() == 0) begin
        chk("unexpected_retire", 1, 0);
      end else begin
        e = wbq.pop_front();
        chk("wb_en", wb_en, e.en);
        if (e.en) begin
          chk("wb_addr", wb_addr, e.addr);
          chk("wb_data", wb_data, e.data);
        end
        chk("retire_latency",
            cyc - e.t0 + 1, e.lat);
      end
    end else if (wb_en) begin
      chk("wb_en_without_retire", 1, 0);
    end
    if (mem_req) begin
      if (req_cnt == 0) begin
        m_we    = mem_we;
        m_addr  = mem_addr;
        m_wdata = mem_wdata;
      end
      req_cnt++;
    end else if (req_cnt != 0) begin
      if (memq.size() == 0) begin
        chk("unexpected_mem_req", 1, 0);
      end else begin
        m = memq.pop_front();
        chk("mem_we", m_we, m.we);
        chk("mem_addr", m_addr, m.addr);
        if (m.we)
          chk("mem_wdata", m_wdata, m.wdata);
        chk("mem_req_cycles", req_cnt, m.cycles);
      end
      req_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ack_wait < 0: never ack. lat == 0: no retire expected.
  task automatic send(
    input logic [3:0]  op,
    input logic [3:0]  rd,
    input logic [31:0] res,
    input logic [31:0] sd,
    input int          ack_wait,
    input logic [31:0] rdata,
    input logic        x_we,
    input logic [15:0] x_addr,
    input logic [31:0] x_wdata,
    input int          x_req,
    input logic        x_en,
    input logic [31:0] x_data,
    input int          x_lat
  );
    int n;
    wb_exp_t  we_;
    mem_exp_t me_;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait_bound", n < 50, 1);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_rd         = rd;
    in_result     = res;
    in_store_data = sd;
    tick();
    in_valid = 1'b0;
    chk("in_ready_low_after_xfer", in_ready, 0);
    if (x_req > 0) begin
      me_.we     = x_we;
      me_.addr   = x_addr;
      me_.wdata  = x_wdata;
      me_.cycles = x_req;
      memq.push_back(me_);
    end
    if (x_lat > 0) begin
      we_.en   = x_en;
      we_.addr = rd;
      we_.data = x_data;
      we_.lat  = x_lat;
      we_.t0   = cyc;
      wbq.push_back(we_);
    end
    if (ack_wait >= 0) begin
      repeat (ack_wait) tick();
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A5A5A;
    end
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    in_valid      = 1'b1;
    in_opcode     = 4'b0000;
    in_rd         = 4'd1;
    in_result     = 32'h11111111;
    in_store_data = 32'h0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'h5A5A5A5A;

    repeat (2) begin
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_retire", retire, 0);
      chk("rst_mem_err", mem_err, 0);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("ready_after_rst", in_ready, 1);

    // ADD r3
    send(4'b0000, 4'd3, 32'h000016A2, 32'h0,
         -1, 32'h0, 1'b0, 16'h0, 32'h0, 0,
         1'b1, 32'h000016A2, 1);
    tick();
    chk("ready_after_wb", in_ready, 1);

    // LDR r2, ack on third request cycle
    send(4'b1101, 4'd2, 32'h00010040, 32'h0,
         2, 32'hDEADBEEF, 1'b0, 16'h0040, 32'h0, 3,
         1'b1, 32'hDEADBEEF, 4);

    // STR, ack in first request cycle
    send(4'b1110, 4'd5, 32'h00000010, 32'hABCDABCD,
         0, 32'h0, 1'b1, 16'h0010, 32'hABCDABCD, 1,
         1'b0, 32'h0, 2);

    // CMP then NOP back-to-back with stray acks
    mem_ack = 1'b1;
    send(4'b1011, 4'd7, 32'h00000001, 32'h0,
         -1, 32'h0, 1'b0, 16'h0, 32'h0, 0,
         1'b0, 32'h0, 1);
    send(4'b1111, 4'd8, 32'h00000002, 32'h0,
         -1, 32'h0, 1'b0, 16'h0, 32'h0, 0,
         1'b0, 32'h0, 1);
    repeat (2) tick();
    mem_ack = 1'b0;

    // Opcodes next to the non-writing ones
    send(4'b1100, 4'd9, 32'hCAFE0001, 32'h0,
         -1, 32'h0, 1'b0, 16'h0, 32'h0, 0,
         1'b1, 32'hCAFE0001, 1);
    send(4'b1010, 4'd10, 32'h0BADF00D, 32'h0,
         -1, 32'h0, 1'b0, 16'h0, 32'h0, 0,
         1'b1, 32'h0BADF00D, 1);

`ifdef MEM_TIMEOUT_EN
    chk("err_before_timeout", mem_err, 0);
    send(4'b1101, 4'd6, 32'h00000080, 32'h0,
         -1, 32'h0, 1'b0, 16'h0080, 32'h0, 4,
         1'b0, 32'h0, 5);
    repeat (6) tick();
    chk("err_sticky", mem_err, 1);
    send(4'b0001, 4'd1, 32'h00000005, 32'h0,
         -1, 32'h0, 1'b0, 16'h0, 32'h0, 0,
         1'b1, 32'h00000005, 1);
    tick();
    chk("err_still_set", mem_err, 1);
`endif

    // LDR killed by reset mid-MEM, then a late ack
    send(4'b1101, 4'd4, 32'h00001234, 32'h0,
         -1, 32'h0, 1'b0, 16'h1234, 32'h0, 2,
         1'b0, 32'h0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_mem_retire", retire, 0);
    mem_ack = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();
    chk("ready_after_mid_rst", in_ready, 1);
    chk("mem_req_after_late_ack", mem_req, 0);
    chk("err_cleared_by_rst", mem_err, 0);

    n = 0;
    while ((wbq.size() != 0 || memq.size() != 0)
           && n < 100) begin
      tick();
      n++;
    end
    chk("wb_queue_drained", wbq.size(), 0);
    chk("mem_queue_drained", memq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
